// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8-bit UART receive sequencer (2-flop sync, mid-bit start qualify, centre sampling).
// Latency: HALF + 9*CLKS_PER_BIT + 1 clocks from rx_s falling to rx_valid (+CLKS_PER_BIT with parity).
// Backpressure: one-entry valid/ready holding register; a byte completing while it is full is dropped with an overrun pulse.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop, adds parity_err).
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 325
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int          HALF      = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        armed, armed_nxt;
    logic        sync1, rx_s;
    logic        stop_ok;
    logic        ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic        par_bad, par_bad_nxt;
    logic        perr_nxt;
`endif

    assign busy = (state != IDLE);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // Sequencer state and bit-timing datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            armed <= armed_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    // Next-state logic; armed blocks retriggering until the line has been seen high after a break.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        armed_nxt = armed;
        stop_ok   = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rx_s, shreg[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = rx_s ^ (^shreg);
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!rx_s) begin
                        ferr_nxt  = 1'b1;
                        armed_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_nxt = 1'b1;
`endif
                    end else begin
                        stop_ok = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Holding register with overrun detection and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= ferr_nxt;
            overrun   <= stop_ok & rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_nxt;
`endif
            if (stop_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
